inst_queue: RTL and testbench
=============================

// Module: inst_queue
// PURPOSE
//   Parametrised instruction queue; next generation of the single-entry instruction register.
//   Buffers up to DEPTH fetched {pc, inst} pairs between fetch and decode.
//   Valid/ready handshake on both sides replaces the bare write enable.
//   Flush discards all buffered entries on branch/jump redirect.
// PARAMETERS
//   INST_W  32  instruction width in bits
//   PC_W    32  width of the PC tagged to each instruction
//   DEPTH   4   entry count; power of two, >= 2
//   CNT_W   $clog2(DEPTH+1)  derived width of count; not overridden
// PORTS
//   clk        in   1       clock, all state updates on posedge
//   rst        in   1       synchronous reset, active-high
//   flush      in   1       drop all entries this cycle
//   in_valid   in   1       fetch presents an instruction
//   in_ready   out  1       queue accepts a push
//   in_inst    in   INST_W  instruction to push
//   in_pc      in   PC_W    PC of in_inst
//   out_valid  out  1       head entry valid
//   out_ready  in   1       decode consumes the head
//   out_inst   out  INST_W  head instruction
//   out_pc     out  PC_W    head PC
//   count      out  CNT_W   occupied entries, 0..DEPTH
// BEHAVIOUR
//   - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0.
//     After reset: out_valid=0, out_inst=0, out_pc=0, in_ready=1.
//     Storage array is not reset. rst overrides flush, push and pop.
//   - Handshake signals:
//     in_ready  = (count != DEPTH); does not depend on out_ready.
//     push      = in_valid & in_ready & ~flush.
//     out_valid = (count != 0).
//     pop       = out_valid & out_ready & ~flush.
//   - Outputs: out_inst/out_pc = storage[rd_ptr] when out_valid, else all-zero (NOP).
//     Combinational from the registered array; no extra register stage.
//   - Latency: a pushed entry is visible at the outputs the cycle after the push.
//     There is no same-cycle bypass, including when the queue is empty.
//   - Push writes storage[wr_ptr] and increments wr_ptr. Pop increments rd_ptr.
//     Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//   - count next value: +1 on push only; -1 on pop only; unchanged on both or neither.
//   - Full with out_ready=1: the pop occurs. No push that cycle (in_ready=0).
//     in_ready rises the following cycle.
//   - Empty: out_ready is ignored; count never underflows.
//   - Flush: pointers and count go to 0 next cycle; the same-cycle push and pop are suppressed.
//     out_valid=0 the cycle after flush; an in_valid instruction that cycle is dropped.
//   - Push and pop in one cycle at a partial fill: both take effect and count holds.
//   - in_valid/in_inst may change freely when in_ready=0; no stall-hold requirement on fetch.
// TESTING
//   1 Reset then idle: rst=1 for 2 cycles -> out_valid=0, out_inst=0, count=0, in_ready=1.
//   2 Fill: push 0x20080005@pc 0x0, 0x20090007@0x4, 0x01095020@0x8, 0xAC0A0000@0xC, out_ready=0.
//     -> count=4, in_ready=0; a 5th in_valid is not accepted.
//   3 Drain order: from the full state hold out_ready=1 for 4 cycles.
//     -> out_inst sequence 0x20080005, 0x20090007, 0x01095020, 0xAC0A0000 with matching PCs.
//     -> count=0 and out_inst=0 after the last pop.
//   4 Concurrent push/pop: 6 queued writes at count=2 with out_ready=1 each cycle.
//     -> count stays 2, pointers wrap past DEPTH, FIFO order is preserved.
//   5 Flush: count=3, then flush=1 with in_valid=1 (0x08000010) and out_ready=1.
//     -> next cycle count=0, out_valid=0; 0x08000010 is absent from all later outputs.
//   6 Reset mid-stream: count=3, assert rst together with in_valid and out_ready.
//     -> next cycle count=0, out_valid=0; the next push appears one cycle after it is accepted.

Source files
------------

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular buffer of {pc, inst}
// pairs with valid/ready on both sides and a flush that empties it on redirect.
module inst_queue #(
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [PC_W-1:0]   pc_mem_q   [DEPTH];
    logic              push, pop;

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign count     = count_q;

    // Head is read straight from the array: a push shows up only after count updates.
    assign out_inst = out_valid ? inst_mem_q[rd_ptr_q] : '0;
    assign out_pc   = out_valid ? pc_mem_q[rd_ptr_q]   : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            inst_mem_q[wr_ptr_q] <= in_inst;
            pc_mem_q[wr_ptr_q]   <= in_pc;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: directed scenarios plus random traffic, checked against a queue model.
module tb_inst_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      in_inst, in_pc, out_inst, out_pc;
    logic [CNT_W-1:0] count;

    inst_queue #(.INST_W(32), .PC_W(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

    ent_t sb[$];          // entries the model holds, head first
    int   mcnt = 0;       // model occupancy for the current cycle
    int   mcnt_next = 0;
    bit   pend_v = 1'b0;
    ent_t pend;
    bit   cur_rs = 1'b1;
    bit   armed = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // One clock: commit the previous cycle's model outcome, then drive new inputs.
    task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                        input bit ordy, input bit fl, input bit rs);
        bit push_ok, pop_ok;
        @(posedge clk);
        if (cur_rs) armed = 1'b1;
        mcnt = mcnt_next;
        if (pend_v) sb.push_back(pend);
        #1;
        rst = rs; flush = fl; in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy;
        cur_rs  = rs;
        push_ok = v && !fl && !rs && (mcnt != DEPTH);
        pop_ok  = ordy && !fl && !rs && (mcnt != 0);
        if (rs || fl) mcnt_next = 0;
        else          mcnt_next = mcnt + int'(push_ok) - int'(pop_ok);
        pend_v    = push_ok;
        pend.inst = inst;
        pend.pc   = pc;
    endtask

    // Monitor: compares every visible output against the model, retires popped heads.
    always @(negedge clk) begin
        if (armed) begin
            chk("count",     64'(count),     64'(mcnt));
            chk("in_ready",  64'(in_ready),  64'(mcnt != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            if (sb.size() == 0) begin
                chk("nop_inst", 64'(out_inst), 64'(0));
                chk("nop_pc",   64'(out_pc),   64'(0));
            end else begin
                chk("head_inst", 64'(out_inst), 64'(sb[0].inst));
                chk("head_pc",   64'(out_pc),   64'(sb[0].pc));
            end
            if (rst || flush) sb.delete();
            else if (out_ready && sb.size() != 0) void'(sb.pop_front());
        end
    end

    logic [31:0] prog [4];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        prog[0] = 32'h20080005; prog[1] = 32'h20090007;
        prog[2] = 32'h01095020; prog[3] = 32'hAC0A0000;

        // Reset then idle
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Fill to full, then offer a fifth instruction that must be refused
        for (int i = 0; i < 4; i++) step(1, prog[i], 32'(4 * i), 0, 0, 0);
        step(1, 32'hDEADBEEF, 32'h10, 0, 0, 0);
        step(1, 32'hDEADBEEF, 32'h10, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Drain in order
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Concurrent push/pop at count=2, pointers wrap
        step(1, 32'h11110000, 32'h100, 0, 0, 0);
        step(1, 32'h11110001, 32'h104, 0, 0, 0);
        for (int i = 2; i < 8; i++) step(1, 32'h11110000 + 32'(i), 32'h100 + 32'(4 * i), 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);

        // Flush with a concurrent push and pop
        for (int i = 0; i < 3; i++) step(1, 32'h22220000 + 32'(i), 32'h200 + 32'(4 * i), 0, 0, 0);
        step(1, 32'h08000010, 32'h20C, 1, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 32'h33330000, 32'h300, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) step(1, 32'h44440000 + 32'(i), 32'h400 + 32'(4 * i), 0, 0, 0);
        step(1, 32'h44449999, 32'h4FC, 1, 0, 1);
        step(1, 32'h55550000, 32'h500, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom, $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2);
        end
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
